// File: rtl/loop_cache_pkg.sv
// rtl/loop_cache_pkg.sv - shared widths, defaults and FSM state type for the loop cache
// Purpose: common definitions imported by the loop cache interface, storage and control.
//   PROGRAM_COUNTER    width of instruction addresses
//   BYTE               width of the live-entry count
//   LOOP_DEPTH_DEFAULT default number of loop-return entries
//   loop_state         control FSM states
package loop_cache_pkg;

  localparam int PROGRAM_COUNTER    = 16;
  localparam int BYTE               = 8;
  localparam int LOOP_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    FAULT = 2'd2
  } loop_state;

endpackage

// File: rtl/loop_cache_if.sv
// rtl/loop_cache_if.sv - core-facing signal bundle of the loop cache
// Purpose: groups the instruction-decode inputs and branch/status outputs.
//   master: core side, drives open_op, close_op, acc_zero, pc
//   slave : loop cache, drives pc_load, pc_loaded, skip_active, depth, full, empty, error
interface loop_cache_if;
  import loop_cache_pkg::*;

  logic                       open_op;
  logic                       close_op;
  logic                       acc_zero;
  logic [PROGRAM_COUNTER-1:0] pc;
  logic                       pc_load;
  logic [PROGRAM_COUNTER-1:0] pc_loaded;
  logic                       skip_active;
  logic [BYTE-1:0]            depth;
  logic                       full;
  logic                       empty;
  logic                       error;

  modport master (
    output open_op, close_op, acc_zero, pc,
    input  pc_load, pc_loaded, skip_active, depth, full, empty, error
  );

  modport slave (
    input  open_op, close_op, acc_zero, pc,
    output pc_load, pc_loaded, skip_active, depth, full, empty, error
  );

endinterface

// File: rtl/loop_lifo.sv
// rtl/loop_lifo.sv - LIFO of loop-return addresses
// Purpose: holds the pc of each open loop; newest entry is presented on top.
//   clk, rst_n  clock, asynchronous active-low reset (clears pointers only)
//   push, din   store din as the new top (ignored when full)
//   pop         discard the top entry (ignored when empty)
//   top         newest entry, valid only when !empty
//   depth       live-entry count; full / empty flags
module loop_lifo
  import loop_cache_pkg::*;
#(
  parameter int DEPTH = LOOP_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PROGRAM_COUNTER-1:0] din,
  output logic [PROGRAM_COUNTER-1:0] top,
  output logic [BYTE-1:0]            depth,
  output logic                       full,
  output logic                       empty
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [BYTE-1:0] CNT_ONE = BYTE'(1);
  localparam logic [BYTE-1:0] DEPTH_B = BYTE'(DEPTH);

  logic [PROGRAM_COUNTER-1:0] mem [DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [BYTE-1:0]            count;

  assign full  = (count == DEPTH_B);
  assign empty = (count == '0);
  assign depth = count;

  // No bypass: top is read from storage, so a push shows up one cycle later.
  // When the stack is full, wr_ptr has wrapped and wr_ptr-1 still names the last slot.
  assign top = mem[wr_ptr - PTR_ONE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push && !full) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      count  <= count + CNT_ONE;
    end else if (pop && !empty) begin
      wr_ptr <= wr_ptr - PTR_ONE;
      count  <= count - CNT_ONE;
    end
  end

  // Storage contents survive reset; entries above depth are don't-care.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/loop_cache.sv
// rtl/loop_cache.sv - loop-return cache with forward-skip and fault handling
// Purpose: services '[' / ']' branches. Taken loop-backs load pc from top+1,
//   zero-accumulator opens skip forward to the matching close, illegal
//   sequences lock into FAULT until reset.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    loop_cache_if.slave (decode inputs, branch target, status)
module loop_cache
  import loop_cache_pkg::*;
#(
  parameter int LOOP_DEPTH = LOOP_DEPTH_DEFAULT,
  parameter int SKIP_W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  loop_cache_if.slave  bus
);

  localparam logic [SKIP_W-1:0]          SKIP_ONE = SKIP_W'(1);
  localparam logic [SKIP_W-1:0]          SKIP_MAX = {SKIP_W{1'b1}};
  localparam logic [PROGRAM_COUNTER-1:0] PC_ONE   = PROGRAM_COUNTER'(1);

  loop_state                  state, state_nxt;
  logic [SKIP_W-1:0]          skip_cnt, skip_cnt_nxt;
  logic                       push, pop, pc_load;
  logic [PROGRAM_COUNTER-1:0] top;
  logic [BYTE-1:0]            depth;
  logic                       full, empty;

  loop_lifo #(
    .DEPTH (LOOP_DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc),
    .top   (top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    push         = 1'b0;
    pop          = 1'b0;
    pc_load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.open_op && bus.close_op) begin
          state_nxt = FAULT;
        end else if (bus.open_op) begin
          if (bus.acc_zero) begin
            // The '[' itself executes; skipping starts with the next instruction.
            state_nxt    = SKIP;
            skip_cnt_nxt = SKIP_ONE;
          end else if (full) begin
            state_nxt = FAULT;
          end else begin
            push = 1'b1;
          end
        end else if (bus.close_op) begin
          if (empty) begin
            state_nxt = FAULT;
          end else if (bus.acc_zero) begin
            pop = 1'b1;
          end else begin
            pc_load = 1'b1;
          end
        end
      end
      SKIP: begin
        // Only nesting is tracked here; the stack is never touched while skipping.
        if (bus.open_op && bus.close_op) begin
          state_nxt = FAULT;
        end else if (bus.open_op) begin
          if (skip_cnt == SKIP_MAX) begin
            state_nxt = FAULT;
          end else begin
            skip_cnt_nxt = skip_cnt + SKIP_ONE;
          end
        end else if (bus.close_op) begin
          if (skip_cnt == SKIP_ONE) begin
            state_nxt    = IDLE;
            skip_cnt_nxt = '0;
          end else begin
            skip_cnt_nxt = skip_cnt - SKIP_ONE;
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = FAULT;
      end
    endcase
  end

  assign bus.pc_load     = pc_load;
  assign bus.pc_loaded   = empty ? '0 : top + PC_ONE;
  assign bus.skip_active = (state != IDLE);
  assign bus.error       = (state == FAULT);
  assign bus.depth       = depth;
  assign bus.full        = full;
  assign bus.empty       = empty;

endmodule

// File: tb/tb_loop_cache.sv
// tb/tb_loop_cache.sv - self-checking bench for loop_cache
module tb_loop_cache;
  import loop_cache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  loop_cache_if bus ();

  loop_cache #(
    .LOOP_DEPTH (16),
    .SKIP_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: stack of return addresses, mode 0=idle 1=skip 2=fault, nesting level.
  logic [15:0] mq [$];
  int          mmode = 0;
  int          mnest = 0;

  typedef struct {
    bit          o;
    bit          c;
    bit          a;
    logic [15:0] pc;
    bit          e_load;
    logic [15:0] e_loaded;
    bit          e_skip;
    logic [7:0]  e_depth;
    bit          e_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit o, input bit c, input bit a, input logic [15:0] p);
    bus.open_op  = o;
    bus.close_op = c;
    bus.acc_zero = a;
    bus.pc       = p;
  endtask

  task automatic model_clear();
    mq.delete();
    mmode = 0;
    mnest = 0;
  endtask

  task automatic model_update(input bit o, input bit c, input bit a, input logic [15:0] p);
    if (mmode == 2) return;
    if (o && c) begin
      mmode = 2;
      return;
    end
    if (mmode == 0) begin
      if (o) begin
        if (a) begin
          mmode = 1;
          mnest = 1;
        end else if (mq.size() == 16) mmode = 2;
        else mq.push_back(p);
      end else if (c) begin
        if (mq.size() == 0) mmode = 2;
        else if (a) mq.pop_back();
      end
    end else begin
      if (o) begin
        if (mnest == 255) mmode = 2;
        else mnest++;
      end else if (c) begin
        mnest--;
        if (mnest == 0) mmode = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input bit o, input bit c, input bit a);
    int          n;
    logic [15:0] e_loaded;
    bit          e_load;
    n        = mq.size();
    e_loaded = 16'h0;
    if (n > 0) e_loaded = mq[n-1] + 16'd1;
    e_load = (mmode == 0) && c && !o && !a && (n > 0);
    chk({tag, " pc_load"},     bus.pc_load,     e_load);
    chk({tag, " pc_loaded"},   bus.pc_loaded,   e_loaded);
    chk({tag, " skip_active"}, bus.skip_active, mmode != 0);
    chk({tag, " depth"},       bus.depth,       n);
    chk({tag, " full"},        bus.full,        n == 16);
    chk({tag, " empty"},       bus.empty,       n == 0);
    chk({tag, " error"},       bus.error,       mmode == 2);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " pc_load"},     bus.pc_load,     0);
    chk({tag, " pc_loaded"},   bus.pc_loaded,   0);
    chk({tag, " skip_active"}, bus.skip_active, 0);
    chk({tag, " depth"},       bus.depth,       0);
    chk({tag, " full"},        bus.full,        0);
    chk({tag, " empty"},       bus.empty,       1);
    chk({tag, " error"},       bus.error,       0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 16'h0);
    #1 reset_checks(tag);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic settle(input bit o, input bit c, input bit a, input logic [15:0] p);
    @(negedge clk);
    drive(o, c, a, p);
    #1;
  endtask

  task automatic step(input bit o, input bit c, input bit a, input logic [15:0] p, input string tag);
    settle(o, c, a, p);
    check_outputs(tag, o, c, a);
    model_update(o, c, a, p);
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 16'h0);

    // Table: loop-back, exit, forward skip with nesting, and 16-bit wrap of top+1.
    //            o  c  a  pc        load loaded    skip depth err
    tbl[0]  = '{1, 0, 0, 16'h0005, 0, 16'h0000, 0, 8'd0, 0};
    tbl[1]  = '{0, 1, 0, 16'h0009, 1, 16'h0006, 0, 8'd1, 0};
    tbl[2]  = '{0, 1, 1, 16'h0009, 0, 16'h0006, 0, 8'd1, 0};
    tbl[3]  = '{0, 0, 0, 16'h000a, 0, 16'h0000, 0, 8'd0, 0};
    tbl[4]  = '{1, 0, 1, 16'h0002, 0, 16'h0000, 0, 8'd0, 0};
    tbl[5]  = '{1, 0, 0, 16'h0003, 0, 16'h0000, 1, 8'd0, 0};
    tbl[6]  = '{0, 1, 0, 16'h0004, 0, 16'h0000, 1, 8'd0, 0};
    tbl[7]  = '{0, 1, 0, 16'h0005, 0, 16'h0000, 1, 8'd0, 0};
    tbl[8]  = '{0, 0, 0, 16'h0006, 0, 16'h0000, 0, 8'd0, 0};
    tbl[9]  = '{1, 0, 0, 16'hffff, 0, 16'h0000, 0, 8'd0, 0};
    tbl[10] = '{0, 1, 0, 16'h1234, 1, 16'h0000, 0, 8'd1, 0};
    tbl[11] = '{0, 1, 1, 16'h1235, 0, 16'h0000, 0, 8'd1, 0};
    tbl[12] = '{0, 0, 0, 16'h1236, 0, 16'h0000, 0, 8'd0, 0};

    do_reset("reset0");
    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      settle(tbl[i].o, tbl[i].c, tbl[i].a, tbl[i].pc);
      chk({t, " pc_load"},     bus.pc_load,     tbl[i].e_load);
      chk({t, " pc_loaded"},   bus.pc_loaded,   tbl[i].e_loaded);
      chk({t, " skip_active"}, bus.skip_active, tbl[i].e_skip);
      chk({t, " depth"},       bus.depth,       tbl[i].e_depth);
      chk({t, " error"},       bus.error,       tbl[i].e_err);
      @(posedge clk);
    end

    // Overflow: 16 pushes fill the stack, the 17th open faults and later closes do nothing.
    do_reset("reset_full");
    for (int i = 0; i < 16; i++) step(1, 0, 0, 16'(100 + i), "fill");
    settle(0, 0, 0, 16'h0);
    chk("full after 16", bus.full, 1);
    chk("depth after 16", bus.depth, 16);
    chk("pc_loaded after 16", bus.pc_loaded, 16'd116);
    step(1, 0, 0, 16'd200, "push17");
    settle(0, 1, 0, 16'd201);
    chk("full fault error", bus.error, 1);
    chk("full fault skip", bus.skip_active, 1);
    chk("full fault pc_load", bus.pc_load, 0);
    chk("full fault depth", bus.depth, 16);
    @(posedge clk);

    // Simultaneous open and close faults without touching the stack.
    do_reset("reset_both");
    step(1, 0, 0, 16'd1, "both push");
    step(1, 1, 0, 16'd2, "both");
    settle(0, 0, 0, 16'd3);
    chk("both error", bus.error, 1);
    chk("both depth", bus.depth, 1);

    // Skip nesting counter saturates at 255; one more open faults.
    do_reset("reset_skipmax");
    step(1, 0, 1, 16'd0, "skip enter");
    for (int i = 0; i < 254; i++) step(1, 0, 0, 16'(i + 1), "skip nest");
    step(1, 0, 0, 16'd999, "skip ovf");
    settle(0, 0, 0, 16'd0);
    chk("skip ovf error", bus.error, 1);

    // Close on empty faults; then asynchronous reset away from the clock edge.
    do_reset("reset_empty");
    step(0, 1, 0, 16'd3, "close empty");
    settle(0, 0, 0, 16'd4);
    chk("close empty error", bus.error, 1);
    chk("close empty skip", bus.skip_active, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 reset_checks("async reset");
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 16'd7);
    #1 check_outputs("first push", 1, 0, 0);
    model_update(1, 0, 0, 16'd7);
    @(posedge clk);
    settle(0, 0, 0, 16'd8);
    chk("first push depth", bus.depth, 1);
    chk("first push pc_loaded", bus.pc_loaded, 16'd8);
    @(posedge clk);

    // Randomised run against the reference model, with occasional resets.
    do_reset("reset_rand");
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit o, c, a;
      if ($urandom_range(0, 99) == 0 || (mmode == 2 && $urandom_range(0, 9) == 0)) begin
        do_reset("rand reset");
      end else begin
        r = $urandom_range(0, 99);
        o = (r < 40) || (r >= 80 && r < 82);
        c = (r >= 40 && r < 82);
        a = ($urandom_range(0, 2) == 0);
        step(o, c, a, 16'($urandom), "rand");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/loop_cache.md
LOOP_CACHE -- requirements
Module: loop_cache

Interface
REQ-001 Parameter LOOP_DEPTH, default 16; number of loop-return entries held.
REQ-002 Parameter SKIP_W, default 8; width of the forward-skip nesting counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 open_op  in  1  current instruction is loop-open ('[').
REQ-007 close_op  in  1  current instruction is loop-close (']').
REQ-008 acc_zero  in  1  accumulator equals zero (from acc_unit).
REQ-009 pc  in  PROGRAM_COUNTER (16)  address of current instruction.
REQ-010 pc_load  out  1  fetch SHALL take pc_loaded this cycle.
REQ-011 pc_loaded  out  PROGRAM_COUNTER  branch target to fetch_unit.
REQ-012 skip_active  out  1  core SHALL suppress all side effects of the current instruction.
REQ-013 depth  out  BYTE  count of live entries.
REQ-014 full, empty  out  1 each  depth==LOOP_DEPTH, depth==0.
REQ-015 error  out  1  sticky fault flag.

Function
REQ-016 FSM states: IDLE, SKIP, FAULT; only IDLE services branches.
REQ-017 IDLE, open_op & !acc_zero: push pc at next edge; depth+1; pc_load=0.
REQ-018 IDLE, open_op & acc_zero: no push; next state SKIP, skip counter=1; skip_active=0 this cycle (the '[' itself executes).
REQ-019 SKIP: skip_active=1 every cycle; open_op increments counter; close_op decrements; close_op with counter==1 returns to IDLE next edge, counter=0.
REQ-020 IDLE, close_op & !acc_zero: pc_load=1 combinationally same cycle; pc_loaded=top+1 (16-bit wrap); stack unchanged.
REQ-021 IDLE, close_op & acc_zero: pop at next edge; depth-1; pc_load=0.
REQ-022 pc_loaded SHALL equal top+1 whenever !empty, else 16'h0; pc_load SHALL be 0 outside IDLE.
REQ-023 Push while full, close_op while empty, skip counter increment at all-ones, or open_op&close_op together: no state change to stack, error=1, next state FAULT.
REQ-024 FAULT: ignore all inputs; pc_load=0, skip_active=1; exit only by reset.
REQ-025 No bypass: a push is visible as top on the cycle after its edge.
REQ-026 Entries beyond depth are don't-care; full and empty SHALL never both be 1.

Reset
REQ-027 Assertion of reset (low) SHALL immediately force: state IDLE, depth 0, empty 1, full 0, error 0, skip_active 0, pc_load 0, pc_loaded 0, skip counter 0.
REQ-028 Reset mid-SKIP or in FAULT SHALL abandon it with no residual state; storage contents need not be cleared.
REQ-029 First push SHALL be honoured on the first rising edge after deassertion.

Structure
REQ-030 definitions package SHALL hold loop_state enum (IDLE, SKIP, FAULT) and LOOP_DEPTH default; PROGRAM_COUNTER and BYTE reused from it.
REQ-031 Storage SHALL be one sub-module, loop_lifo (push, pop, top, depth, full, empty), with loop_cache holding FSM, skip counter and branch logic.

Verification
REQ-032 Reset, acc_zero=0, open_op at pc=5, then close_op at pc=9 -> pc_load=1, pc_loaded=6, depth stays 1.
REQ-033 Same, then close_op with acc_zero=1 -> pc_load=0, depth 1->0, empty=1.
REQ-034 open_op acc_zero=1 at pc=2, then open, close, close at pc 3..5 -> skip_active 1 on pcs 3,4,5; IDLE at pc 6; depth 0.
REQ-035 16 pushes then 17th open_op (acc_zero=0) -> full=1, error=1, FAULT, later close_op gives pc_load=0.
REQ-036 close_op with empty after reset -> error=1, pc_load=0; reset low mid-cycle -> all outputs at REQ-027 values immediately.
